// File: rtl/vx_afu_axil_ctrl_if.sv
// AXI4-Lite control-port bundle between the shell's s_axi_ctrl master and the AFU control slave.
interface vx_afu_axil_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/vx_afu_axil_ctrl.sv
// AXI4-Lite ap_ctrl_hs control slave for the Vortex AFU: control/IRQ registers, caps and 64-bit kernel args.
// Optional kernel watchdog enabled by defining VX_AFU_CTRL_WATCHDOG_EN.
module vx_afu_axil_ctrl #(
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_ARGS       = 4,
    parameter int TIMEOUT_CYCLES = 1 << 24
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    vx_afu_axil_ctrl_if.slave        s_axi_ctrl,
    input  logic [63:0]              dev_caps,
    output logic                     ap_start,
    input  logic                     ap_ready,
    input  logic                     ap_done,
    input  logic                     ap_idle,
    output logic [64*NUM_ARGS-1:0]   args,
    output logic                     interrupt
);
    localparam int AW = ADDR_WIDTH;

`ifdef VX_AFU_CTRL_WATCHDOG_EN
    localparam int IRQ_W = 3;
`else
    localparam int IRQ_W = 2;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;
    typedef enum logic [1:0] {C_IDLE, C_START, C_RUN} cstate_t;

    wstate_t r_wstate, w_wstate_next;
    rstate_t r_rstate, w_rstate_next;
    cstate_t r_cstate, w_cstate_next;

    logic [AW-1:0]    r_waddr;
    logic [31:0]      r_rdata;
    logic             r_done, r_ready, r_auto_restart, r_gie, r_interrupt;
    logic [IRQ_W-1:0] r_ier, r_isr, w_isr_set;
    logic             w_timeout;
    logic             w_set_ready, w_set_done;
    logic [31:0]      w_rd_data;
    logic [31:0]      w_arg_rd [NUM_ARGS];

    function automatic logic f_hit(input logic [AW-1:0] a, input int unsigned off);
        return (a >> 2) == (AW'(off) >> 2);
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old_val, input logic [31:0] din,
                                            input logic [3:0] strb);
        logic [31:0] v;
        for (int b = 0; b < 4; b++) v[8*b +: 8] = strb[b] ? din[8*b +: 8] : old_val[8*b +: 8];
        return v;
    endfunction

    // Decoded write/read strobes
    logic w_wr_en, w_ar_hs, w_wr_ctrl, w_wr_gie, w_wr_ier, w_wr_isr, w_start_req, w_cor, w_arg_wr;
    assign w_wr_en     = (r_wstate == W_DATA) && s_axi_ctrl.wvalid;
    assign w_ar_hs     = (r_rstate == R_IDLE) && s_axi_ctrl.arvalid;
    assign w_wr_ctrl   = w_wr_en && s_axi_ctrl.wstrb[0] && f_hit(r_waddr, 32'h00);
    assign w_wr_gie    = w_wr_en && s_axi_ctrl.wstrb[0] && f_hit(r_waddr, 32'h04);
    assign w_wr_ier    = w_wr_en && s_axi_ctrl.wstrb[0] && f_hit(r_waddr, 32'h08);
    assign w_wr_isr    = w_wr_en && s_axi_ctrl.wstrb[0] && f_hit(r_waddr, 32'h0C);
    assign w_start_req = w_wr_ctrl && s_axi_ctrl.wdata[0];
    assign w_cor       = w_ar_hs && f_hit(s_axi_ctrl.araddr, 32'h00);
    assign w_arg_wr    = w_wr_en && (r_cstate == C_IDLE);

    // ---------------- write channel FSM ----------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wstate <= W_IDLE;
            r_waddr  <= '0;
        end else begin
            r_wstate <= w_wstate_next;
            if (r_wstate == W_IDLE && s_axi_ctrl.awvalid) r_waddr <= s_axi_ctrl.awaddr;
        end
    end

    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (s_axi_ctrl.awvalid) w_wstate_next = W_DATA;
            W_DATA:  if (s_axi_ctrl.wvalid)  w_wstate_next = W_RESP;
            W_RESP:  if (s_axi_ctrl.bready)  w_wstate_next = W_IDLE;
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_ctrl.awready = (r_wstate == W_IDLE);
        s_axi_ctrl.wready  = (r_wstate == W_DATA);
        s_axi_ctrl.bvalid  = (r_wstate == W_RESP);
        s_axi_ctrl.bresp   = 2'b00;
    end

    // ---------------- read channel FSM ----------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
        end else begin
            r_rstate <= w_rstate_next;
            if (w_ar_hs) r_rdata <= w_rd_data;
        end
    end

    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (s_axi_ctrl.arvalid) w_rstate_next = R_DATA;
            R_DATA:  if (s_axi_ctrl.rready)  w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_ctrl.arready = (r_rstate == R_IDLE);
        s_axi_ctrl.rvalid  = (r_rstate == R_DATA);
        s_axi_ctrl.rdata   = r_rdata;
        s_axi_ctrl.rresp   = 2'b00;
    end

    // ---------------- kernel control FSM ----------------
`ifdef VX_AFU_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout, w_wd_fire;

    assign w_wd_fire = (r_cstate != C_IDLE) && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign w_timeout = r_timeout;

    // Counter restarts on every (re)entry to START so auto-restart gets a fresh budget.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_cstate_next == C_IDLE || (w_cstate_next == C_START && r_cstate != C_START))
                r_wd_cnt <= '0;
            else
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            if (w_wd_fire)
                r_timeout <= 1'b1;
            else if (w_cstate_next == C_START && r_cstate != C_START)
                r_timeout <= 1'b0;
        end
    end
    assign w_isr_set = {w_wd_fire, w_set_ready, w_set_done};
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_timeout = 1'b0;
    assign w_isr_set = {w_set_ready, w_set_done};
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_cstate <= C_IDLE;
        else           r_cstate <= w_cstate_next;
    end

    always_comb begin
        w_cstate_next = r_cstate;
        case (r_cstate)
            C_IDLE:  if (w_start_req) w_cstate_next = C_START;
            C_START: if (ap_ready)    w_cstate_next = ap_done ? C_IDLE : C_RUN;
            C_RUN:   if (ap_done)     w_cstate_next = r_auto_restart ? C_START : C_IDLE;
            default: w_cstate_next = C_IDLE;
        endcase
`ifdef VX_AFU_CTRL_WATCHDOG_EN
        if (w_wd_fire) w_cstate_next = C_IDLE;
`endif
    end

    always_comb begin
        ap_start    = (r_cstate == C_START);
        w_set_ready = (r_cstate == C_START) && ap_ready;
        w_set_done  = ((r_cstate == C_START) && ap_ready && ap_done) || ((r_cstate == C_RUN) && ap_done);
    end

    // ---------------- control / interrupt registers ----------------
    // Hardware set events take priority over clear-on-read and ISR toggles.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_done         <= 1'b0;
            r_ready        <= 1'b0;
            r_auto_restart <= 1'b0;
            r_gie          <= 1'b0;
            r_ier          <= '0;
            r_isr          <= '0;
            r_interrupt    <= 1'b0;
        end else begin
            if (w_set_done)      r_done <= 1'b1;
            else if (w_cor)      r_done <= 1'b0;
            if (w_set_ready)     r_ready <= 1'b1;
            else if (w_cor)      r_ready <= 1'b0;
            if (w_wr_ctrl)       r_auto_restart <= s_axi_ctrl.wdata[7];
            if (w_wr_gie)        r_gie <= s_axi_ctrl.wdata[0];
            if (w_wr_ier)        r_ier <= s_axi_ctrl.wdata[IRQ_W-1:0];
            r_isr       <= (r_isr ^ (w_wr_isr ? s_axi_ctrl.wdata[IRQ_W-1:0] : '0)) | w_isr_set;
            r_interrupt <= r_gie & (|(r_isr & r_ier));
        end
    end

    assign interrupt = r_interrupt;

    // ---------------- kernel argument registers ----------------
    for (genvar gi = 0; gi < NUM_ARGS; gi++) begin : g_arg
        localparam int unsigned LO = 32'h18 + 8 * gi;
        logic [63:0] r_arg;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                r_arg <= '0;
            end else if (w_arg_wr) begin
                if (f_hit(r_waddr, LO))
                    r_arg[31:0]  <= f_merge(r_arg[31:0], s_axi_ctrl.wdata, s_axi_ctrl.wstrb);
                if (f_hit(r_waddr, LO + 4))
                    r_arg[63:32] <= f_merge(r_arg[63:32], s_axi_ctrl.wdata, s_axi_ctrl.wstrb);
            end
        end

        assign args[64*gi +: 64] = r_arg;
        assign w_arg_rd[gi] = f_hit(s_axi_ctrl.araddr, LO)     ? r_arg[31:0]  :
                              f_hit(s_axi_ctrl.araddr, LO + 4) ? r_arg[63:32] : 32'h0;
    end

    // Read mux; unmapped offsets fall through to zero.
    always_comb begin
        w_rd_data = 32'h0;
        if (f_hit(s_axi_ctrl.araddr, 32'h00))
            w_rd_data = {24'h0, r_auto_restart, 2'b00, w_timeout, r_ready, ap_idle, r_done, ap_start};
        else if (f_hit(s_axi_ctrl.araddr, 32'h04))
            w_rd_data = {31'h0, r_gie};
        else if (f_hit(s_axi_ctrl.araddr, 32'h08))
            w_rd_data = 32'(r_ier);
        else if (f_hit(s_axi_ctrl.araddr, 32'h0C))
            w_rd_data = 32'(r_isr);
        else if (f_hit(s_axi_ctrl.araddr, 32'h10))
            w_rd_data = dev_caps[31:0];
        else if (f_hit(s_axi_ctrl.araddr, 32'h14))
            w_rd_data = dev_caps[63:32];
        for (int i = 0; i < NUM_ARGS; i++) w_rd_data = w_rd_data | w_arg_rd[i];
    end
endmodule

// File: tb/tb_vx_afu_axil_ctrl.sv
// Directed self-checking bench for vx_afu_axil_ctrl: register map, start/done handshake, IRQs, backpressure.
module tb_vx_afu_axil_ctrl;
    localparam int AW = 8;
    localparam int NA = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vx_afu_axil_ctrl_if #(.ADDR_WIDTH(AW)) axi ();

    logic [63:0]      dev_caps;
    logic             ap_start, ap_ready, ap_done, ap_idle, interrupt;
    logic [64*NA-1:0] args;

    vx_afu_axil_ctrl #(.ADDR_WIDTH(AW), .NUM_ARGS(NA), .TIMEOUT_CYCLES(16)) dut (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .s_axi_ctrl (axi),
        .dev_caps   (dev_caps),
        .ap_start   (ap_start),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .args       (args),
        .interrupt  (interrupt)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return axi.awready;
            1:       return axi.wready;
            2:       return axi.bvalid;
            3:       return axi.arready;
            default: return axi.rvalid;
        endcase
    endfunction

    // Waits (bounded) at negedges until the selected ready/valid is high; returns at that negedge.
    task automatic wait_hs(input int s, input string tag);
        int n = 0;
        @(negedge clk);
        while (!sig(s) && n < 32) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_handshake"}, 64'(sig(s)), 64'd1);
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
        axi.awvalid = 1'b1; axi.awaddr = addr;
        wait_hs(0, "aw"); tick(); axi.awvalid = 1'b0;
        axi.wvalid = 1'b1; axi.wdata = data; axi.wstrb = strb;
        wait_hs(1, "w"); tick(); axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        wait_hs(2, "b"); tick(); axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data);
        axi.arvalid = 1'b1; axi.araddr = addr;
        wait_hs(3, "ar"); tick(); axi.arvalid = 1'b0;
        axi.rready = 1'b1;
        wait_hs(4, "r"); data = axi.rdata; tick(); axi.rready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        axi.awvalid = 0; axi.awaddr = '0; axi.wvalid = 0; axi.wdata = '0; axi.wstrb = '0;
        axi.bready = 0; axi.arvalid = 0; axi.araddr = '0; axi.rready = 0;
        ap_ready = 0; ap_done = 0; ap_idle = 1; dev_caps = 64'h1234_5678_9ABC_DEF0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ap_start", 64'(ap_start), 0);
        chk("rst_interrupt", 64'(interrupt), 0);
        chk("rst_bvalid", 64'(axi.bvalid), 0);
        chk("rst_rvalid", 64'(axi.rvalid), 0);
        chk("rst_arg0", args[63:0], 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        axi_read(8'h00, d); chk("ctrl_idle", 64'(d), 64'h4);
        axi_read(8'h10, d); chk("caps_lo", 64'(d), 64'h9ABCDEF0);
        axi_read(8'h14, d); chk("caps_hi", 64'(d), 64'h12345678);

        // byte-masked argument write
        axi_write(8'h20, 32'hDEADBEEF, 4'h3);
        axi_write(8'h24, 32'h1, 4'hF);
        chk("arg1", args[127:64], 64'h00000001_0000BEEF);
        axi_read(8'h20, d); chk("arg1_lo_rd", 64'(d), 64'h0000BEEF);
        axi_read(8'h24, d); chk("arg1_hi_rd", 64'(d), 64'h1);
        axi_write(8'h38, 32'hFFFFFFFF, 4'hF);
        axi_read(8'h38, d); chk("unmapped_rd", 64'(d), 0);
        chk("arg3_untouched", args[255:192], 0);

        // start / ready / done / interrupt
        axi_write(8'h04, 32'h1, 4'hF);
        axi_write(8'h08, 32'h1, 4'hF);
        axi_read(8'h08, d); chk("ier_rd", 64'(d), 64'h1);
        ap_idle = 0;
        axi_write(8'h00, 32'h1, 4'hF);
        chk("start_hi", 64'(ap_start), 1);
        repeat (3) tick();
        chk("start_hold", 64'(ap_start), 1);
        ap_ready = 1; tick(); ap_ready = 0;
        chk("start_drop", 64'(ap_start), 0);
        tick();
        chk("irq_ready_masked", 64'(interrupt), 0);
        ap_done = 1; tick(); ap_done = 0; ap_idle = 1;
        chk("irq_lat0", 64'(interrupt), 0);
        tick();
        chk("irq_hi", 64'(interrupt), 1);
        axi_read(8'h00, d); chk("ctrl_done", 64'(d), 64'hE);
        axi_read(8'h00, d); chk("ctrl_cor", 64'(d), 64'h4);
        axi_read(8'h0C, d); chk("isr", 64'(d), 64'h3);
        axi_write(8'h0C, 32'h1, 4'hF);
        chk("irq_cleared", 64'(interrupt), 0);
        axi_read(8'h0C, d); chk("isr_toggled", 64'(d), 64'h2);

        // write-channel backpressure
        axi.awvalid = 1; axi.awaddr = 8'h28;
        wait_hs(0, "bp_aw"); tick(); axi.awvalid = 0;
        repeat (2) begin
            tick();
            chk("bp_aw_blocked", 64'(axi.awready), 0);
        end
        axi.wvalid = 1; axi.wdata = 32'hCAFEF00D; axi.wstrb = 4'hF;
        wait_hs(1, "bp_w"); tick(); axi.wvalid = 0;
        repeat (4) begin
            chk("bp_bvalid_hold", 64'(axi.bvalid), 1);
            chk("bp_aw_wait", 64'(axi.awready), 0);
            tick();
        end
        axi.bready = 1;
        wait_hs(2, "bp_b");
        chk("bp_bresp", 64'(axi.bresp), 0);
        tick(); axi.bready = 0;
        chk("bp_bvalid_drop", 64'(axi.bvalid), 0);
        chk("bp_aw_free", 64'(axi.awready), 1);
        axi_read(8'h28, d); chk("bp_data", 64'(d), 64'hCAFEF00D);

        // auto-restart and argument lock while running
        ap_idle = 0;
        axi_write(8'h00, 32'h81, 4'hF);
        chk("ar_start", 64'(ap_start), 1);
        ap_ready = 1; tick(); ap_ready = 0;
        chk("ar_run", 64'(ap_start), 0);
        axi_write(8'h18, 32'h55, 4'hF);
        axi_read(8'h18, d); chk("arg_locked", 64'(d), 0);
        ap_done = 1; tick(); ap_done = 0;
        chk("ar_restart", 64'(ap_start), 1);
        axi_read(8'h00, d); chk("ar_ctrl", 64'(d), 64'h8B);
        axi_write(8'h00, 32'h0, 4'hF);
        ap_ready = 1; ap_done = 1; tick(); ap_ready = 0; ap_done = 0; ap_idle = 1;
        chk("both_idle", 64'(ap_start), 0);
        axi_read(8'h00, d); chk("both_flags", 64'(d), 64'hE);
        axi_write(8'h1C, 32'hA5A5A5A5, 4'hF);
        chk("arg0_idle_wr", args[63:0], 64'hA5A5A5A5_00000000);

`ifdef VX_AFU_CTRL_WATCHDOG_EN
        axi_write(8'h08, 32'h4, 4'hF);
        ap_idle = 0;
        axi_write(8'h00, 32'h1, 4'hF);
        chk("wd_start", 64'(ap_start), 1);
        repeat (20) tick();
        chk("wd_idle", 64'(ap_start), 0);
        axi_read(8'h00, d); chk("wd_ctrl_timeout", 64'(d[4]), 1);
        axi_read(8'h0C, d); chk("wd_isr", 64'(d[2]), 1);
        ap_idle = 1;
`else
        axi_write(8'h00, 32'h10, 4'hF);
        axi_read(8'h00, d); chk("no_timeout_bit", 64'(d), 64'h4);
`endif

        // reset in the middle of a run and an open read
        ap_idle = 0;
        axi_write(8'h00, 32'h1, 4'hF);
        chk("mid_start", 64'(ap_start), 1);
        axi.arvalid = 1; axi.araddr = 8'h00;
        wait_hs(3, "mid_ar"); tick(); axi.arvalid = 0;
        chk("mid_rvalid", 64'(axi.rvalid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_start", 64'(ap_start), 0);
        chk("mid_rst_rvalid", 64'(axi.rvalid), 0);
        chk("mid_rst_arg0", args[63:0], 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
